// File: rtl/flash_arbiter.sv
// Two-client round-robin arbiter for an SPI NOR flash doing 0x03 reads, SPI mode 0 at clk/2.
// Optional FLASH_WAKE_EN: sends release-power-down (0xAB) and waits WAKE_CYCLES before first grant.
module flash_arbiter #(
   parameter int unsigned WAKE_CYCLES = 16,
   parameter int unsigned CS_IDLE     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [23:0] addr0,
   input  logic [23:0] addr1,
   input  logic [15:0] len0,
   input  logic [15:0] len1,
   output logic [1:0]  gnt,
   output logic [15:0] rdata,
   output logic        valid,
   output logic        done0,
   output logic        done1,
   output logic        spi_cs,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int unsigned CNT_MAX = (WAKE_CYCLES > CS_IDLE) ? WAKE_CYCLES : CS_IDLE;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {IDLE, WAKE, WAKE_WAIT, CMD, DATA, GAP} state_t;

   state_t        state_q, state_d;
   logic          cs_q, sclk_q, own, last, abort_q;
   logic [31:0]   sh;
   logic [14:0]   rx;
   logic [4:0]    bit_cnt;
   logic [15:0]   word_cnt, len_q;
   logic [CW-1:0] cnt;
   logic [1:0]    gnt_q;

   logic        win, can_grant, owner_req, quit, cmd_end, word_end, last_word, gap_end;
   logic [15:0] sel_len;
   logic [23:0] sel_addr;

   // Simultaneous requests go to the client not served last.
   assign win       = (req0 & req1) ? ~last : req1;
   assign sel_len   = win ? len1 : len0;
   assign sel_addr  = win ? addr1 : addr0;
   assign can_grant = (state_q == IDLE) && (req0 | req1) && (gnt_q == 2'b00) && !done0 && !done1;
   assign owner_req = own ? req1 : req0;
   assign quit      = abort_q | ~owner_req;
   assign cmd_end   = (state_q == CMD)  && sclk_q && (bit_cnt == 5'd31);
   assign word_end  = (state_q == DATA) && sclk_q && (bit_cnt == 5'd15);
   assign last_word = (word_cnt + 16'd1) == len_q;
   assign gap_end   = (state_q == GAP)  && (cnt == CW'(CS_IDLE - 1));

`ifdef FLASH_WAKE_EN
   logic wake_end;
   assign wake_end = (state_q == WAKE) && !cs_q && sclk_q && (bit_cnt == 5'd7);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
`ifdef FLASH_WAKE_EN
         state_q <= WAKE;
`else
         state_q <= IDLE;
`endif
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (can_grant && sel_len != 16'd0) state_d = CMD;
         CMD:  if (cmd_end) state_d = quit ? GAP : DATA;
         DATA: if (word_end && (quit || last_word)) state_d = GAP;
         GAP:  if (gap_end) state_d = IDLE;
`ifdef FLASH_WAKE_EN
         WAKE:      if (wake_end) state_d = WAKE_WAIT;
         WAKE_WAIT: if (cnt == CW'(WAKE_CYCLES - 1)) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_q     <= 1'b1;
         sclk_q   <= 1'b0;
         own      <= 1'b0;
         last     <= 1'b1;
         abort_q  <= 1'b0;
         sh       <= '0;
         rx       <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         len_q    <= '0;
         cnt      <= '0;
         gnt_q    <= '0;
         rdata    <= '0;
         valid    <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
      end else begin
         valid <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state_q)
            IDLE: begin
               sclk_q <= 1'b0;
               // A non-zero gnt while idle is a zero-length grant: answer with done.
               if (gnt_q != 2'b00) begin
                  gnt_q <= '0;
                  done0 <= gnt_q[0];
                  done1 <= gnt_q[1];
               end else if (can_grant) begin
                  own      <= win;
                  last     <= win;
                  len_q    <= sel_len;
                  word_cnt <= '0;
                  bit_cnt  <= '0;
                  abort_q  <= 1'b0;
                  gnt_q    <= win ? 2'b10 : 2'b01;
                  if (sel_len != 16'd0) begin
                     cs_q <= 1'b0;
                     sh   <= {8'h03, sel_addr};
                  end
               end
            end
            CMD, DATA: begin
               sclk_q <= ~sclk_q;
               if (!owner_req) abort_q <= 1'b1;
               if (sclk_q) begin
                  sh      <= {sh[30:0], 1'b0};
                  rx      <= {rx[13:0], spi_miso};
                  bit_cnt <= bit_cnt + 5'd1;
               end
               if (cmd_end && quit) begin
                  cs_q  <= 1'b1;
                  gnt_q <= '0;
                  cnt   <= '0;
               end
               if (word_end) begin
                  bit_cnt  <= '0;
                  word_cnt <= word_cnt + 16'd1;
                  if (!quit) begin
                     rdata <= {rx, spi_miso};
                     valid <= 1'b1;
                  end
                  if (quit || last_word) begin
                     cs_q  <= 1'b1;
                     gnt_q <= '0;
                     cnt   <= '0;
                     if (!quit) begin
                        done0 <= ~own;
                        done1 <= own;
                     end
                  end
               end
            end
            GAP: cnt <= cnt + CW'(1);
`ifdef FLASH_WAKE_EN
            WAKE: begin
               if (cs_q) begin
                  cs_q    <= 1'b0;
                  sh      <= {8'hAB, 24'h0};
                  bit_cnt <= '0;
               end else begin
                  sclk_q <= ~sclk_q;
                  if (sclk_q) begin
                     sh      <= {sh[30:0], 1'b0};
                     bit_cnt <= bit_cnt + 5'd1;
                  end
                  if (wake_end) begin
                     cs_q <= 1'b1;
                     cnt  <= '0;
                  end
               end
            end
            WAKE_WAIT: cnt <= cnt + CW'(1);
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      spi_cs   = cs_q;
      spi_sclk = sclk_q;
      spi_mosi = ~cs_q & sh[31];
      gnt      = gnt_q;
   end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed self-checking bench for flash_arbiter with a behavioural SPI read-only flash model.
module tb_flash_arbiter;
   localparam int unsigned WAKE_CYCLES = 16;
   localparam int unsigned CS_IDLE     = 4;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [23:0] addr0 = '0, addr1 = '0;
   logic [15:0] len0 = '0, len1 = '0;
   logic [1:0]  gnt;
   logic [15:0] rdata;
   logic        valid, done0, done1, spi_cs, spi_sclk, spi_mosi;
   logic        spi_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   flash_arbiter #(.WAKE_CYCLES(WAKE_CYCLES), .CS_IDLE(CS_IDLE)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
      .gnt(gnt), .rdata(rdata), .valid(valid), .done0(done0), .done1(done1),
      .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   // Flash model: after the 32-bit command, shifts mem[] out MSB first on falling sclk.
   logic [15:0] mem [0:7];
   int          fall_cnt = 0, rise_cnt = 0;
   logic [31:0] cmd_cap = '0;

   always @(negedge spi_sclk or posedge spi_cs) begin : flash_out
      int f, w;
      if (spi_cs) begin
         fall_cnt <= 0;
         spi_miso <= 1'b0;
      end else begin
         f = fall_cnt + 1;
         fall_cnt <= f;
         if (f >= 32) begin
            w = (f - 32) / 16;
            if (w < 8) spi_miso <= mem[w][15 - ((f - 32) % 16)];
         end
      end
   end

   always @(posedge spi_sclk or posedge spi_cs) begin
      if (spi_cs) rise_cnt <= 0;
      else begin
         if (rise_cnt < 32) cmd_cap <= {cmd_cap[30:0], spi_mosi};
         rise_cnt <= rise_cnt + 1;
      end
   end

   task automatic apply_reset();
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({spi_cs, spi_sclk, spi_mosi, gnt, valid, done0, done1} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_outputs: got cs/sclk/mosi/gnt/valid/d0/d1=%b want 10000000",
                  {spi_cs, spi_sclk, spi_mosi, gnt, valid, done0, done1});
      end
      checks++;
      if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
      reset = 1'b0;
   endtask

   task automatic test_basic_read();
      int nvalid = 0, ndone = 0, gnt_bad = 0;
      logic [15:0] exp;
      apply_reset();
      mem[0] = 16'hA55A; mem[1] = 16'h1234;
      addr0 = 24'h100000; len0 = 16'd2; req0 = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (spi_cs === 1'b0 && gnt !== 2'b01) gnt_bad++;
         if (valid === 1'b1) begin
            exp = (nvalid == 0) ? 16'hA55A : 16'h1234;
            checks++;
            if (rdata !== exp) begin errors++; $display("FAIL basic_word%0d: got %h want %h", nvalid, rdata, exp); end
            nvalid++;
         end
         if (done0 === 1'b1) begin
            ndone++; req0 = 1'b0;
            checks++;
            if (gnt !== 2'b00) begin errors++; $display("FAIL basic_gnt_clear: got %b want 00", gnt); end
            break;
         end
      end
      repeat (10) begin
         @(negedge clk);
         if (done0 === 1'b1) ndone++;
         if (valid === 1'b1) nvalid++;
      end
      checks++;
      if (cmd_cap !== 32'h03100000) begin errors++; $display("FAIL basic_cmd: got %h want 03100000", cmd_cap); end
      checks++;
      if (nvalid != 2) begin errors++; $display("FAIL basic_valid_count: got %0d want 2", nvalid); end
      checks++;
      if (ndone != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
      checks++;
      if (gnt_bad != 0) begin errors++; $display("FAIL basic_gnt: got %0d cycles with gnt!=01 want 0", gnt_bad); end
   endtask

   task automatic test_round_robin();
      logic [1:0] first_gnt = 2'b00;
      logic d0 = 1'b0, d1 = 1'b0, order_bad = 1'b0;
      int gap = 0, gap_meas = -1, nvalid = 0, bad_word = 0;
      logic [1:0] gnt2 = 2'b00;
      apply_reset();
      mem[0] = 16'hC3C3;
      addr0 = 24'h000010; addr1 = 24'h000020; len0 = 16'd1; len1 = 16'd1;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (first_gnt == 2'b00 && gnt !== 2'b00) first_gnt = gnt;
         if (valid === 1'b1) begin nvalid++; if (rdata !== 16'hC3C3) bad_word++; end
         if (d0 && gap_meas < 0) begin
            if (spi_cs === 1'b1) gap++;
            else begin gap_meas = gap; gnt2 = gnt; end
         end
         if (done1 === 1'b1) begin
            if (!d0) order_bad = 1'b1;
            d1 = 1'b1; req1 = 1'b0;
            break;
         end
         if (done0 === 1'b1) begin d0 = 1'b1; req0 = 1'b0; if (spi_cs === 1'b1) gap = 1; end
      end
      checks++;
      if (first_gnt !== 2'b01) begin errors++; $display("FAIL rr_first_gnt: got %b want 01", first_gnt); end
      checks++;
      if (!d1 || order_bad) begin errors++; $display("FAIL rr_order: got d0=%b d1=%b order_bad=%b want 1 1 0", d0, d1, order_bad); end
      checks++;
      if (gap_meas < int'(CS_IDLE)) begin errors++; $display("FAIL rr_cs_gap: got %0d want >= %0d", gap_meas, CS_IDLE); end
      checks++;
      if (gnt2 !== 2'b10) begin errors++; $display("FAIL rr_second_gnt: got %b want 10", gnt2); end
      checks++;
      if (cmd_cap !== 32'h03000020) begin errors++; $display("FAIL rr_cmd1: got %h want 03000020", cmd_cap); end
      checks++;
      if (nvalid != 2 || bad_word != 0) begin errors++; $display("FAIL rr_words: got %0d valid %0d bad want 2 0", nvalid, bad_word); end
   endtask

   task automatic test_len_zero();
      int gc = -1, dc = -1, cs_bad = 0, extra = 0;
      logic [1:0] gnt_at_done = 2'b11;
      apply_reset();
      len1 = 16'd0; addr1 = 24'h000300; req1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (spi_cs !== 1'b1 || spi_sclk !== 1'b0) cs_bad++;
         if (done0 === 1'b1) extra++;
         if (gc < 0 && gnt === 2'b10) gc = i;
         if (done1 === 1'b1) begin dc = i; gnt_at_done = gnt; req1 = 1'b0; break; end
      end
      repeat (6) begin
         @(negedge clk);
         if (spi_cs !== 1'b1) cs_bad++;
         if (done1 === 1'b1 || done0 === 1'b1 || gnt !== 2'b00) extra++;
      end
      checks++;
      if (gc < 0 || dc != gc + 1) begin errors++; $display("FAIL len0_done_timing: got grant@%0d done@%0d want done one after grant", gc, dc); end
      checks++;
      if (gnt_at_done !== 2'b00) begin errors++; $display("FAIL len0_gnt_clear: got %b want 00", gnt_at_done); end
      checks++;
      if (cs_bad != 0) begin errors++; $display("FAIL len0_spi_idle: got %0d busy cycles want 0", cs_bad); end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL len0_extra: got %0d stray events want 0", extra); end
   endtask

   task automatic test_abort();
      int nvalid = 0, hi_at = -1, extra_v = 0, extra_d = 0;
      apply_reset();
      for (int k = 0; k < 8; k++) mem[k] = 16'(k * 16'h1111 + 1);
      addr0 = 24'h000000; len0 = 16'd8; req0 = 1'b1;
      for (int i = 0; i < 1000 && nvalid < 3; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            checks++;
            if (rdata !== mem[nvalid]) begin errors++; $display("FAIL abort_word%0d: got %h want %h", nvalid, rdata, mem[nvalid]); end
            nvalid++;
         end
      end
      req0 = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (valid === 1'b1) extra_v++;
         if (done0 === 1'b1) extra_d++;
         if (hi_at < 0 && spi_cs === 1'b1) hi_at = i;
      end
      repeat (10) begin
         @(negedge clk);
         if (valid === 1'b1) extra_v++;
         if (done0 === 1'b1) extra_d++;
      end
      checks++;
      if (nvalid != 3 || hi_at < 0) begin errors++; $display("FAIL abort_cs_rise: got valid=%0d cs_high_at=%0d want 3 and <=32", nvalid, hi_at); end
      checks++;
      if (extra_v != 0) begin errors++; $display("FAIL abort_valid: got %0d extra want 0", extra_v); end
      checks++;
      if (extra_d != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", extra_d); end
      checks++;
      if (gnt !== 2'b00) begin errors++; $display("FAIL abort_gnt: got %b want 00", gnt); end
   endtask

   task automatic test_reset_mid();
      int nvalid = 0, ndone = 0, seen = 0;
      logic [15:0] first_word = '0;
      apply_reset();
      mem[0] = 16'hBEEF; mem[1] = 16'hF00D; mem[2] = 16'h0F0F; mem[3] = 16'h8001;
      addr0 = 24'h0ABCDE; len0 = 16'd4; req0 = 1'b1;
      for (int i = 0; i < 300 && seen == 0; i++) begin
         @(negedge clk);
         if (valid === 1'b1) seen = 1;
      end
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({spi_cs, gnt, valid, done0} !== 5'b10000) begin
         errors++; $display("FAIL midreset_abort: got cs/gnt/valid/done0=%b want 10000", {spi_cs, gnt, valid, done0});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin if (nvalid == 0) first_word = rdata; nvalid++; end
         if (done0 === 1'b1) begin ndone++; req0 = 1'b0; break; end
      end
      checks++;
      if (cmd_cap !== 32'h030ABCDE) begin errors++; $display("FAIL midreset_cmd: got %h want 030ABCDE", cmd_cap); end
      checks++;
      if (nvalid != 4 || ndone != 1) begin errors++; $display("FAIL midreset_restart: got %0d valid %0d done want 4 1", nvalid, ndone); end
      checks++;
      if (first_word !== 16'hBEEF) begin errors++; $display("FAIL midreset_word0: got %h want BEEF", first_word); end
   endtask

`ifdef FLASH_WAKE_EN
   task automatic test_wake();
      int hi = 0, ndone = 0, phase = 0;
      logic [7:0] wake_cmd = '0;
      reset = 1'b1; mem[0] = 16'h0001;
      addr0 = 24'h000040; len0 = 16'd1; req0 = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (phase == 0 && spi_cs === 1'b0) phase = 1;
         else if (phase == 1 && spi_cs === 1'b1) begin phase = 2; wake_cmd = cmd_cap[7:0]; hi = 1; end
         else if (phase == 2) begin if (spi_cs === 1'b1) hi++; else phase = 3; end
         if (done0 === 1'b1) begin ndone++; req0 = 1'b0; break; end
      end
      checks++;
      if (wake_cmd !== 8'hAB) begin errors++; $display("FAIL wake_cmd: got %h want AB", wake_cmd); end
      checks++;
      if (hi < int'(WAKE_CYCLES)) begin errors++; $display("FAIL wake_wait: got %0d want >= %0d", hi, WAKE_CYCLES); end
      checks++;
      if (ndone != 1 || cmd_cap !== 32'h03000040) begin errors++; $display("FAIL wake_read: got done=%0d cmd=%h want 1 03000040", ndone, cmd_cap); end
   endtask
`endif

   initial begin
`ifdef FLASH_WAKE_EN
      test_wake();
`endif
      test_reset();
      test_basic_read();
      test_round_robin();
      test_len_zero();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
